// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the MAC datapath: Q-format defaults,
// control/state types, and the rounding-shift and saturation helpers.
package fxp_pkg;

  localparam int unsigned FXP_N      = 16;
  localparam int unsigned FXP_Q      = 12;
  localparam int unsigned FXP_ACC_W  = 32;
  localparam int unsigned FXP_CNT_W  = 16;

  // Helpers operate on a fixed wide signed container; callers narrow the
  // result with a size cast. Widths up to 63 bits are representable.
  localparam int unsigned FXP_WIDE_W = 64;
  typedef logic signed [FXP_WIDE_W-1:0] fxp_wide_t;

  // Accumulator occupancy: IDLE means the next beat starts a new dot product.
  typedef enum logic {
    ACC_IDLE,
    ACC_OPEN
  } acc_state_t;

  // Per-beat control flags travelling alongside the product.
  typedef struct packed {
    logic first;
    logic last;
    logic mode;
  } fxp_ctl_t;

  // Arithmetic right shift by q with round half toward +inf.
  function automatic fxp_wide_t fxp_rnd_shr(input fxp_wide_t x, input int unsigned q);
    fxp_wide_t half;
    if (q == 0) return x;
    half = fxp_wide_t'(1) <<< (q - 1);
    return (x + half) >>> q;
  endfunction

  function automatic fxp_wide_t fxp_max(input int unsigned w);
    return (fxp_wide_t'(1) <<< (w - 1)) - fxp_wide_t'(1);
  endfunction

  function automatic fxp_wide_t fxp_min(input int unsigned w);
    return -(fxp_wide_t'(1) <<< (w - 1));
  endfunction

  // True when x does not fit a w-bit two's complement value.
  function automatic logic fxp_out_of_range(input fxp_wide_t x, input int unsigned w);
    return (x > fxp_max(w)) || (x < fxp_min(w));
  endfunction

  // Clamp x to the w-bit two's complement range.
  function automatic fxp_wide_t fxp_sat(input fxp_wide_t x, input int unsigned w);
    if (x > fxp_max(w)) return fxp_max(w);
    if (x < fxp_min(w)) return fxp_min(w);
    return x;
  endfunction

endpackage

// File: rtl/fxp_mult_rnd.sv
// Stage-1 registered multiplier: full-precision signed product, rescaled by
// Q with rounding, saturated to the accumulator width. Captures on en_i.
module fxp_mult_rnd
  import fxp_pkg::*;
#(
  parameter int unsigned N     = FXP_N,
  parameter int unsigned Q     = FXP_Q,
  parameter int unsigned ACC_W = FXP_ACC_W
) (
  input  logic                    clk,
  input  logic                    sclr,
  input  logic                    en_i,
  input  logic signed [N-1:0]     a_i,
  input  logic signed [N-1:0]     b_i,
  output logic signed [ACC_W-1:0] prod_o,
  output logic                    sat_o
);

  logic signed [2*N-1:0]   full_d;
  fxp_wide_t               scaled_d;
  logic signed [ACC_W-1:0] prod_d, prod_q;
  logic                    sat_d, sat_q;

  // Multiply, round-shift and saturate the incoming operand pair.
  always_comb begin
    full_d   = (2*N)'(a_i) * (2*N)'(b_i);
    scaled_d = fxp_rnd_shr(fxp_wide_t'(full_d), Q);
    sat_d    = fxp_out_of_range(scaled_d, ACC_W);
    prod_d   = ACC_W'(fxp_sat(scaled_d, ACC_W));
  end

  // Product register, loaded only for accepted beats.
  always_ff @(posedge clk) begin
    if (sclr) begin
      prod_q <= '0;
      sat_q  <= 1'b0;
    end else if (en_i) begin
      prod_q <= prod_d;
      sat_q  <= sat_d;
    end
  end

  assign prod_o = prod_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/fxp_mac_pipe.sv
// Two-stage pipelined signed fixed-point multiply-accumulate with optional
// preload, saturating accumulation, sticky overflow and valid/ready flow.
module fxp_mac_pipe
  import fxp_pkg::*;
#(
  parameter int unsigned N     = FXP_N,
  parameter int unsigned Q     = FXP_Q,
  parameter int unsigned ACC_W = FXP_ACC_W,
  parameter int unsigned CNT_W = FXP_CNT_W
) (
  input  logic                    clk,
  input  logic                    sclr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic                    mode,
  input  logic signed [N-1:0]     a,
  input  logic signed [N-1:0]     b,
  input  logic signed [ACC_W-1:0] c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] p,
  output logic                    ovf,
  output logic [CNT_W-1:0]        count
);

  logic adv, accept, s2_fire;

  // Stage 1 state
  logic                    s1_valid_q;
  fxp_ctl_t                s1_ctl_q;
  logic signed [ACC_W-1:0] s1_c_q;
  logic signed [ACC_W-1:0] s1_prod;
  logic                    s1_sat;

  // Accumulator state
  acc_state_t              acc_state_q, acc_state_d;
  logic                    eff_first;
  logic signed [ACC_W-1:0] acc_q;
  logic                    ovf_acc_q;
  logic [CNT_W-1:0]        cnt_q;

  // Stage 2 combinational results
  logic signed [ACC_W-1:0] base;
  fxp_wide_t               sum_w;
  logic                    sum_sat;
  logic signed [ACC_W-1:0] sum_d;
  logic                    ovf_d;
  logic [CNT_W-1:0]        cnt_d;

  // Output registers
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] p_q;
  logic                    ovf_q;
  logic [CNT_W-1:0]        count_q;

  // The whole pipeline advances only when the output slot is free or draining.
  always_comb begin
    adv     = !out_valid_q || out_ready;
    accept  = in_valid && adv;
    s2_fire = s1_valid_q && adv;
  end

  assign in_ready = adv;

  fxp_mult_rnd #(
    .N     (N),
    .Q     (Q),
    .ACC_W (ACC_W)
  ) u_mult (
    .clk    (clk),
    .sclr   (sclr),
    .en_i   (accept),
    .a_i    (a),
    .b_i    (b),
    .prod_o (s1_prod),
    .sat_o  (s1_sat)
  );

  // Stage-1 valid and sideband capture alongside the registered product.
  always_ff @(posedge clk) begin
    if (sclr) begin
      s1_valid_q <= 1'b0;
      s1_ctl_q   <= '0;
      s1_c_q     <= '0;
    end else if (adv) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_ctl_q <= '{first: in_first, last: in_last, mode: mode};
        s1_c_q   <= c;
      end
    end
  end

  // Accumulator occupancy state register.
  always_ff @(posedge clk) begin
    if (sclr) acc_state_q <= ACC_IDLE;
    else      acc_state_q <= acc_state_d;
  end

  // A processed last beat closes the dot product; any other beat opens it.
  always_comb begin
    acc_state_d = acc_state_q;
    if (s2_fire) acc_state_d = s1_ctl_q.last ? ACC_IDLE : ACC_OPEN;
  end

  // A beat reaching an idle accumulator starts a new dot product.
  always_comb begin
    eff_first = s1_ctl_q.first || (acc_state_q == ACC_IDLE);
  end

  // Stage-2 accumulate: pick the base, add, saturate, update sticky and count.
  // An implicit first (idle accumulator, in_first low) always starts from zero.
  always_comb begin
    if (eff_first) base = (s1_ctl_q.first && s1_ctl_q.mode) ? s1_c_q : '0;
    else           base = acc_q;
    sum_w   = fxp_wide_t'(base) + fxp_wide_t'(s1_prod);
    sum_sat = fxp_out_of_range(sum_w, ACC_W);
    sum_d   = ACC_W'(fxp_sat(sum_w, ACC_W));
    ovf_d   = (eff_first ? 1'b0 : ovf_acc_q) | s1_sat | sum_sat;
    if (eff_first)  cnt_d = CNT_W'(1);
    else if (&cnt_q) cnt_d = cnt_q;
    else            cnt_d = cnt_q + CNT_W'(1);
  end

  // Accumulator, sticky overflow and term counter registers.
  always_ff @(posedge clk) begin
    if (sclr) begin
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
    end else if (s2_fire) begin
      acc_q     <= sum_d;
      ovf_acc_q <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  // Result register: a new result write takes priority over delivery clear.
  always_ff @(posedge clk) begin
    if (sclr) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else if (s2_fire && s1_ctl_q.last) begin
      out_valid_q <= 1'b1;
      p_q         <= sum_d;
      ovf_q       <= ovf_d;
      count_q     <= cnt_d;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule
